membank_node_arbiter: RTL
=========================

// Module: membank_node_arbiter
// PURPOSE
//  Controller and arbiter in front of one memorybankNode (node-info table). Shares the single
//  bank port between a write requester (packet RX / table update) and a read requester (routing
//  lookup), with round-robin fairness. Sequences the bank's wr_en/index/data_in timing and
//  returns read data over a valid/ready handshake. Sits between the cluster/route logic and the bank.
// PARAMETERS
//  WORD_W  16  bank word width
//  ADDR_W  6   bank index width
//  DEPTH   64  bank entries (<= 2**ADDR_W)
//  RD_LAT  1   cycles from mem_index stable to mem_data_out valid (>=1)
// PORTS
//  clk           in   1       clock; all state on posedge
//  rst           in   1       asynchronous, active-high reset
//  wr_req        in   1       write request; held with wr_index/wr_data until wr_gnt
//  wr_index      in   ADDR_W  write address
//  wr_data       in   WORD_W  write data
//  wr_gnt        out  1       write accepted this cycle (1-cycle pulse)
//  rd_req        in   1       read request; held with rd_index until rd_gnt
//  rd_index      in   ADDR_W  read address
//  rd_gnt        out  1       read accepted this cycle (1-cycle pulse)
//  rd_valid      out  1       rd_data valid; held until rd_ready
//  rd_data       out  WORD_W  read result
//  rd_ready      in   1       consumer takes rd_data on posedge with rd_valid&rd_ready
//  clr_start     in   1       start full-table clear (MEMBANK_CLR_EN only)
//  clr_done      out  1       clear complete pulse (MEMBANK_CLR_EN only)
//  busy          out  1       state != IDLE
//  mem_wr_en     out  1       to bank wr_en
//  mem_index     out  ADDR_W  to bank index
//  mem_data_in   out  WORD_W  to bank data_in
//  mem_data_out  in   WORD_W  from bank data_out
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, rr_last=READ (write wins first tie), pending read dropped.
//  - FSM states: IDLE, WR, RD, RSP, CLR.
//  - IDLE: gnts combinational from state+reqs; priority clr_start > tie-break > single request.
//    Both reqs: grant the one NOT granted last (rr_last updated on every grant). Accept = gnt high.
//    On accept: mem_index<=index (mem_data_in<=wr_data for write); next state WR or RD.
//  - WR: exactly 1 cycle, mem_wr_en=1, index/data stable; -> IDLE. Write costs 2 cycles.
//  - RD: mem_wr_en=0; counter runs RD_LAT cycles; on last, rd_data<=mem_data_out, rd_valid<=1 -> RSP.
//    Read accepted in cycle t => rd_valid high from cycle t+1+RD_LAT.
//  - RSP: rd_valid held, rd_data stable until rd_valid&rd_ready; then rd_valid<=0 -> IDLE.
//    No new grant while in RSP (backpressure stalls both requesters).
//  - mem_wr_en is never high outside WR/CLR; mem_index/mem_data_in hold last value otherwise.
//  - Ordering: ops serialized; read granted after a write to the same index returns new data.
//  - Requests arriving outside IDLE are not granted; gnt never asserted outside IDLE.
//  - busy = (state != IDLE); combinational from state register.
//  - Async rst mid-operation: immediate return to reset values; in-flight write may or may not
//    have landed; no rd_valid issued for the aborted read.
// CONFIGURATION
//  MEMBANK_CLR_EN defined: clr_start sampled in IDLE (beats pending reqs, no gnt that cycle);
//    CLR state writes 0 to index 0..DEPTH-1, one per cycle, mem_wr_en=1 for DEPTH cycles;
//    clr_done pulses 1 cycle on the cycle after last write, state -> IDLE; rr_last unchanged.
//  Not defined: CLR state absent, clr_start ignored, clr_done tied 0.
// TESTING
//  1 Reset: assert rst mid-cycle -> all outputs 0 asynchronously, busy 0.
//  2 wr_req idx=2 data=15 -> wr_gnt pulse at t, mem_wr_en=1 idx=2 data=15 at t+1, IDLE at t+2.
//  3 After 2, rd_req idx=2, rd_ready=1, RD_LAT=1 -> rd_gnt at t, rd_valid=1 rd_data=15 at t+2.
//  4 wr_req & rd_req held together from reset -> grants alternate W,R,W,R; none starved.
//  5 rd_ready=0 for 5 cycles in RSP -> rd_valid/rd_data stable, wr_req not granted until release.
//  6 MEMBANK_CLR_EN: write idx=4 data=45, clr_start -> 64 write cycles, clr_done pulse,
//    read idx=4 returns 0; without macro clr_start has no effect and read returns 45.

Source files
------------

// File: rtl/membank_node_arbiter.sv
// rtl/membank_node_arbiter.sv - round-robin arbiter and sequencer for one node-info memory bank
//
// Purpose
//   Shares the single port of a memorybankNode between a write requester (packet RX /
//   table update) and a read requester (routing lookup). Ties between the two are broken
//   round-robin. It sequences the bank's wr_en/index/data_in and returns read data over a
//   valid/ready handshake.
//
// Optional feature
//   MEMBANK_CLR_EN : when defined, clr_start launches a full-table clear (DEPTH writes of 0)
//                    and clr_done pulses when it finishes. When undefined, clr_start is
//                    ignored and clr_done stays 0.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   wr_req/wr_index/wr_data       write request, held until wr_gnt
//   wr_gnt                        write accepted (1-cycle pulse, only in IDLE)
//   rd_req/rd_index               read request, held until rd_gnt
//   rd_gnt                        read accepted (1-cycle pulse, only in IDLE)
//   rd_valid/rd_data/rd_ready     read response, held until rd_valid & rd_ready
//   clr_start/clr_done            table clear start / completion pulse
//   busy                          controller not in IDLE
//   mem_wr_en/mem_index/
//   mem_data_in/mem_data_out      bank port
module membank_node_arbiter #(
  parameter int WORD_W = 16,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_index,
  input  logic [WORD_W-1:0] wr_data,
  output logic              wr_gnt,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_index,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [WORD_W-1:0] rd_data,
  input  logic              rd_ready,
  input  logic              clr_start,
  output logic              clr_done,
  output logic              busy,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_index,
  output logic [WORD_W-1:0] mem_data_in,
  input  logic [WORD_W-1:0] mem_data_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_RSP,
    S_CLR
  } state_t;

  localparam int                CNT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(RD_LAT - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_t           state;
  state_t           state_n;
  logic             rr_last;   // 1: read was granted last, so a write wins the next tie
  logic [CNT_W-1:0] rd_cnt;
  logic             clr_go;

`ifdef MEMBANK_CLR_EN
  assign clr_go = clr_start;
`else
  assign clr_go = 1'b0;
  // Clear datapath is compiled out; keep its inputs/constants referenced.
  logic [ADDR_W:0] cfg_unused;
  assign cfg_unused = {clr_start, LAST_IDX};
`endif

  assign busy      = (state != S_IDLE);
  assign mem_wr_en = (state == S_WR) || (state == S_CLR);

  always_comb begin
    wr_gnt  = 1'b0;
    rd_gnt  = 1'b0;
    state_n = state;
    case (state)
      S_IDLE: begin
        // Grants are combinational, so keep them low while reset is held.
        if (rst) begin
          state_n = S_IDLE;
        end else if (clr_go) begin
          state_n = S_CLR;
        end else if (wr_req && rd_req) begin
          if (rr_last) wr_gnt = 1'b1;
          else         rd_gnt = 1'b1;
        end else if (wr_req) begin
          wr_gnt = 1'b1;
        end else if (rd_req) begin
          rd_gnt = 1'b1;
        end
        if (wr_gnt)      state_n = S_WR;
        else if (rd_gnt) state_n = S_RD;
      end
      S_WR: state_n = S_IDLE;
      S_RD: begin
        if (rd_cnt == CNT_LAST) state_n = S_RSP;
      end
      S_RSP: begin
        if (rd_ready) state_n = S_IDLE;
      end
      S_CLR: begin
`ifdef MEMBANK_CLR_EN
        if (mem_index == LAST_IDX) state_n = S_IDLE;
`else
        state_n = S_IDLE;
`endif
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      rr_last     <= 1'b1;
      mem_index   <= '0;
      mem_data_in <= '0;
      rd_cnt      <= '0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      clr_done    <= 1'b0;
    end else begin
      state    <= state_n;
      clr_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (state_n == S_CLR) begin
            mem_index   <= '0;
            mem_data_in <= '0;
          end else if (wr_gnt) begin
            mem_index   <= wr_index;
            mem_data_in <= wr_data;
            rr_last     <= 1'b0;
          end else if (rd_gnt) begin
            mem_index <= rd_index;
            rr_last   <= 1'b1;
            rd_cnt    <= '0;
          end
        end
        S_RD: begin
          // Index has been stable since entering RD; sample the bank on the last count.
          if (rd_cnt == CNT_LAST) begin
            rd_data  <= mem_data_out;
            rd_valid <= 1'b1;
          end else begin
            rd_cnt <= rd_cnt + CNT_W'(1);
          end
        end
        S_RSP: begin
          if (rd_ready) rd_valid <= 1'b0;
        end
        S_CLR: begin
`ifdef MEMBANK_CLR_EN
          // mem_data_in stays 0; walk the index one entry per cycle.
          if (mem_index == LAST_IDX) clr_done  <= 1'b1;
          else                       mem_index <= mem_index + ADDR_W'(1);
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
